// File: rtl/request_marshal_fifo.sv
// request_marshal_fifo: round-robin method-call marshaller feeding a narrow beat pipe.
// Accepted calls are packed as {zero pad, arguments, 32-bit tag} (tag = channel+1),
// held in a DEPTH-entry message FIFO, and sent as BEATS beats of BEAT_WIDTH bits,
// low beat first, with a last-beat marker.
// Ports:
//   CLK, RST        clock; synchronous active-high reset
//   request_ena     per-channel call valid
//   request_data    channel i arguments at [i*ARG_WIDTH +: ARG_WIDTH]
//   request_rdy     per-channel accept (at most one bit high)
//   pipe_enq_ena    beat valid
//   pipe_enq_v      beat data
//   pipe_enq_last   final beat of a message
//   pipe_enq_rdy    sink accepts beat
//   msg_count       messages fully sent (wraps)
module request_marshal_fifo #(
    parameter int unsigned NUM_METHODS = 2,
    parameter int unsigned ARG_WIDTH   = 64,
    parameter int unsigned BEAT_WIDTH  = 32,
    parameter int unsigned DEPTH       = 4
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic [NUM_METHODS-1:0]           request_ena,
    input  logic [NUM_METHODS*ARG_WIDTH-1:0] request_data,
    output logic [NUM_METHODS-1:0]           request_rdy,
    output logic                             pipe_enq_ena,
    output logic [BEAT_WIDTH-1:0]            pipe_enq_v,
    output logic                             pipe_enq_last,
    input  logic                             pipe_enq_rdy,
    output logic [31:0]                      msg_count
);

    localparam int unsigned MSG_W = ARG_WIDTH + 32;
    localparam int unsigned BEATS = (MSG_W + BEAT_WIDTH - 1) / BEAT_WIDTH;
    localparam int unsigned PAD_W = BEATS * BEAT_WIDTH;
    localparam int unsigned RR_W  = (NUM_METHODS > 1) ? $clog2(NUM_METHODS) : 1;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned B_W   = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [RR_W-1:0]  rr;
    logic [RR_W-1:0]  grant_idx;
    logic             grant_any;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [B_W-1:0]   beat_idx;
    logic [PAD_W-1:0] mem [DEPTH];
    logic [PAD_W-1:0] msg;
    logic [PAD_W-1:0] head;
    logic             full;
    logic             empty;
    logic             push;
    logic             xfer;
    logic             pop;

    // Round-robin search: first requesting channel at or after rr.
    always_comb begin
        int unsigned idx;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < NUM_METHODS; k++) begin
            idx = (32'(rr) + k) % NUM_METHODS;
            if (!grant_any && request_ena[idx]) begin
                grant_any = 1'b1;
                grant_idx = RR_W'(idx);
            end
        end
    end

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    // Fullness is judged at cycle start: a same-cycle pop never frees a slot for a push.
    assign push  = grant_any & !full & !RST;

    always_comb begin
        request_rdy = '0;
        if (push) begin
            request_rdy[grant_idx] = 1'b1;
        end
    end

    // Pack the granted call: tag in the low word, arguments above, zero pad on top.
    always_comb begin
        msg                   = '0;
        msg[31:0]             = 32'(32'(grant_idx) + 32'd1);
        msg[32 +: ARG_WIDTH]  = request_data[32'(grant_idx)*ARG_WIDTH +: ARG_WIDTH];
    end

    assign head          = mem[rd_ptr];
    assign pipe_enq_ena  = !empty & !RST;
    assign pipe_enq_v    = head[32'(beat_idx)*BEAT_WIDTH +: BEAT_WIDTH];
    assign pipe_enq_last = (beat_idx == B_W'(BEATS - 1));
    assign xfer          = pipe_enq_ena & pipe_enq_rdy;
    assign pop           = xfer & pipe_enq_last;

    // Message storage; contents need no reset since count gates visibility.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= msg;
        end
    end

    // Control state: pointers, occupancy, beat index, arbiter pointer, sent counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            beat_idx  <= '0;
            rr        <= '0;
            msg_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                rr     <= (grant_idx == RR_W'(NUM_METHODS - 1)) ? '0 : grant_idx + RR_W'(1);
            end
            if (xfer) begin
                if (pipe_enq_last) begin
                    beat_idx  <= '0;
                    rd_ptr    <= rd_ptr + PTR_W'(1);
                    msg_count <= msg_count + 32'd1;
                end else begin
                    beat_idx <= beat_idx + B_W'(1);
                end
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (!push && pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule
